uart_tx_fifo_drain: RTL and testbench

- Downstream consumer of the team's synchronous byte FIFO.
- Pops bytes whenever the FIFO is non-empty and serialises each one as an 8N1 UART frame on a single TX line.
- Accounts for the FIFO's registered read data, which is valid one cycle after rd_en.
- Sits between the FIFO read port and the chip-level UART pin.

---
 rtl/uart_tx_fifo_drain.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// Drains a registered-read byte FIFO and serialises each byte as an 8N1 UART frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fifo_drain #(
   parameter int data_width   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int cnt_width    = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  tx_en,
   input  logic [data_width-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int                   IDX_W    = (data_width > 1) ? $clog2(data_width) : 1;
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(data_width - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(CLKS_PER_BIT - 1);
   localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_WAIT,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

   state_e                  state_q, state_d;
   logic [cnt_width-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [data_width-1:0]   shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
   logic                    parity_q, parity_d;
`endif
   logic                    tx_q, tx_d;
   logic                    busy_q, busy_d;
   logic                    rd_q, rd_d;
   logic                    done_q, done_d;
   logic                    bit_end;

   assign bit_end = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default first so every path assigns state_d; a missing branch would infer a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (tx_en && !fifo_empty) state_d = S_POP;
         S_POP:    state_d = S_WAIT;
         S_WAIT:   state_d = S_START;
         S_START:  if (bit_end) state_d = S_DATA;
`ifdef UART_TX_PARITY_EN
         S_DATA:   if (bit_end && idx_q == IDX_LAST) state_d = S_PARITY;
         S_PARITY: if (bit_end) state_d = S_STOP;
`else
         S_DATA:   if (bit_end && idx_q == IDX_LAST) state_d = S_STOP;
`endif
         S_STOP:   if (bit_end) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Baud counter, bit index and shift register; the FIFO word is valid during WAIT
   always_comb begin
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         S_IDLE, S_POP: begin
            cnt_d = '0;
            idx_d = '0;
         end
         S_WAIT: begin
            cnt_d    = '0;
            idx_d    = '0;
            shift_d  = fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_data;
`endif
         end
         default: begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_ONE;
            if (state_q == S_DATA && bit_end) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_ONE;
            end
         end
      endcase
   end

   // Outputs are registered, so they are decoded from the next state to line up with it
   always_comb begin
      rd_d   = (state_d == S_POP);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         rd_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register updates from pre-edge values.
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         rd_q     <= rd_d;
         done_q   <= done_d;
      end
   end

   assign fifo_rd_en = rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: directed frame table, multi-cycle corner sequences,
// then randomized traffic against a cycle-offset reference model.
module tb_uart_tx_fifo_drain;

   localparam int W = 8;
   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = W + 3;
`else
   localparam int NBITS = W + 2;
`endif
   localparam int FRAME = NBITS * C;

   logic         CLK        = 1'b0;
   logic         RST_N      = 1'b1;
   logic         tx_en      = 1'b0;
   logic [W-1:0] fifo_data  = '0;
   logic         fifo_empty = 1'b1;
   logic         fifo_rd_en, tx, busy, frame_done;

   logic         push_req = 1'b0;
   logic [W-1:0] push_val = '0;
   logic [W-1:0] fifo_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: start cycle of the current frame (the pop cycle) and its byte
   int           mt = 0;
   int           ms = -1000;
   logic [W-1:0] mb = '0;
   logic [W-1:0] shadow[$];

   typedef struct {
      logic [W-1:0] data;
      logic         exp_par;
      logic [0:W+1] exp_frame;   // start, d0..d7, stop as seen on the line
   } vec_t;

   vec_t vecs[6];

   always #5 CLK = ~CLK;

   uart_tx_fifo_drain #(
      .data_width  (W),
      .CLKS_PER_BIT(C),
      .cnt_width   (16)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .tx_en      (tx_en),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Synchronous FIFO with registered read data
   always @(posedge CLK) begin
      if (fifo_rd_en && fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      if (push_req) fifo_q.push_back(push_val);
      fifo_empty <= (fifo_q.size() == 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] b);
      push_req = 1'b1;
      push_val = b;
      @(negedge CLK);
      push_req = 1'b0;
   endtask

   function automatic int exp_zeros(input logic [W-1:0] b);
      int z = C * (1 + W - $countones(b));
`ifdef UART_TX_PARITY_EN
      if (!(^b)) z += C;
`endif
      return z;
   endfunction

   // Expected {tx, busy, fifo_rd_en, frame_done} at offset d from the pop cycle
   function automatic logic [3:0] model_exp(input int d, input logic [W-1:0] b);
      logic txv = 1'b1;
      int   k;
      if (d >= 2 && d < 2 + FRAME) begin
         k = (d - 2) / C;
         if (k == 0)      txv = 1'b0;
         else if (k <= W) txv = b[k-1];
`ifdef UART_TX_PARITY_EN
         else if (k == W + 1) txv = ^b;
`endif
      end
      return {txv, (d >= 0 && d <= 1 + FRAME), d == 0, d == 1 + FRAME};
   endfunction

   // One model-checked cycle; inputs for this cycle are set by the caller beforehand
   task automatic cycle(input string tag);
      check($sformatf("%s t=%0d", tag, mt), {tx, busy, fifo_rd_en, frame_done}, model_exp(mt - ms, mb));
      if (fifo_rd_en) check($sformatf("%s rd_while_empty t=%0d", tag, mt), fifo_empty, 1'b0);
      if (mt - ms > 1 + FRAME && tx_en && shadow.size() != 0) begin
         ms = mt + 1;
         mb = shadow.pop_front();
      end
      if (push_req) shadow.push_back(push_val);
      @(negedge CLK);
      push_req = 1'b0;
      mt++;
   endtask

   // Push one byte into an empty FIFO and compare every cycle of the frame against the table
   task automatic frame_check(input vec_t v);
      logic txv;
      int   k;
      push(v.data);
      for (int o = 0; o <= FRAME + 2; o++) begin
         txv = 1'b1;
         if (o >= 3) begin
            k = (o - 3) / C;
            if (k <= W + 1) txv = v.exp_frame[k];
`ifdef UART_TX_PARITY_EN
            if (k == W + 1) txv = v.exp_par;
            if (k == W + 2) txv = 1'b1;
`endif
         end
         check($sformatf("frame %02h +%0d", v.data, o), {tx, busy, fifo_rd_en, frame_done},
               {txv, o >= 1, o == 1, o == FRAME + 2});
         @(negedge CLK);
      end
   endtask

   // Wait (bounded) for a pop, then sample the frame at mid-bit
   task automatic capture(input string tag, output logic [W-1:0] b, output int lat);
      lat = 0;
      b   = '0;
      while (fifo_rd_en !== 1'b1 && lat < 200) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, " pop_seen"}, lat < 200, 1'b1);
      repeat (2 + C / 2) @(negedge CLK);
      check({tag, " start"}, tx, 1'b0);
      for (int k = 0; k < W; k++) begin
         repeat (C) @(negedge CLK);
         b[k] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (C) @(negedge CLK);
      check({tag, " parity"}, tx, ^b);
`endif
      repeat (C) @(negedge CLK);
      check({tag, " stop"}, tx, 1'b1);
   endtask

   initial begin
      logic [W-1:0] b;
      int           lat, zeros, rd_n, fd_n, gap, extra_rd;
      bit           gap_done;

      vecs[0] = '{8'hA5, 1'b0, 10'b0101001011};
      vecs[1] = '{8'h00, 1'b0, 10'b0000000001};
      vecs[2] = '{8'hFF, 1'b0, 10'b0111111111};
      vecs[3] = '{8'h3C, 1'b0, 10'b0001111001};
      vecs[4] = '{8'h07, 1'b1, 10'b0111000001};
      vecs[5] = '{8'h03, 1'b0, 10'b0110000001};

      #1 RST_N = 1'b0;
      #2 check("reset state", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;

      // Idle with empty FIFO and transmit enabled
      tx_en = 1'b1;
      for (int i = 0; i < 50; i++) begin
         check($sformatf("idle %0d", i), {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
         @(negedge CLK);
      end

      for (int i = 0; i < 6; i++) frame_check(vecs[i]);

      // Back-to-back 0x00 then 0xFF: fixed 3-cycle gap, two pops
      push(8'h00);
      push(8'hFF);
      rd_n = fifo_rd_en ? 1 : 0;
      fd_n = 0; zeros = 0; gap = 0; gap_done = 1'b0;
      for (int i = 0; i < 2 * (FRAME + 3) + 10; i++) begin
         @(negedge CLK);
         if (fifo_rd_en) rd_n++;
         if (frame_done) fd_n++;
         if (!tx) zeros++;
         if (fd_n == 1 && !frame_done && !gap_done) begin
            if (tx) gap++;
            else    gap_done = 1'b1;
         end
      end
      check("b2b pops", rd_n, 2);
      check("b2b frame_done pulses", fd_n, 2);
      check("b2b gap", gap, 3);
      check("b2b low cycles", zeros, exp_zeros(8'h00) + exp_zeros(8'hFF));

      // tx_en dropped mid-frame with a second byte queued
      push(8'h3C);
      push(8'h81);
      check("t4 pop", fifo_rd_en, 1'b1);
      zeros = 0; extra_rd = 0;
      for (int o = 2; o <= FRAME + 2; o++) begin
         @(negedge CLK);
         if (o == 13) tx_en = 1'b0;
         if (!tx) zeros++;
         if (fifo_rd_en) extra_rd++;
         if (o == FRAME + 2) check("t4 frame_done", frame_done, 1'b1);
      end
      check("t4 low cycles", zeros, exp_zeros(8'h3C));
      check("t4 extra pop", extra_rd, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check($sformatf("t4 hold %0d", i), {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
      end
      tx_en = 1'b1;
      capture("t4 second", b, lat);
      check("t4 repop latency", lat, 1);
      check("t4 second byte", b, 8'h81);
      repeat (C) @(negedge CLK);

      // Reset during data bit 3 of 0x5A, then the next entry is popped
      push(8'h5A);
      push(8'hC3);
      repeat (19) @(negedge CLK);
      check("t5 bit3 busy", busy, 1'b1);
      check("t5 bit3 tx", tx, 1'b1);
      RST_N = 1'b0;
      #1 check("t5 abort", {tx, busy, fifo_rd_en, frame_done}, 4'b1000);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      capture("t5 repop", b, lat);
      check("t5 repop latency", lat, 1);
      check("t5 repop byte", b, 8'hC3);
      repeat (C) @(negedge CLK);
      check("t5 fifo drained", fifo_empty, 1'b1);

      // Randomized traffic against the reference model
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      mt = 0;
      ms = -1000;
      shadow.delete();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) tx_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) begin
            push_req = 1'b1;
            push_val = W'($urandom);
         end
         cycle("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
